mul_div_unit: RTL and testbench



---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mul_div_unit_cond_negate.sv | 12 +
 rtl/mul_div_unit.sv | 169 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op encodings, FSM states and the default datapath width.
package mdu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

endpackage

// File: rtl/mul_div_unit_cond_negate.sv
// Conditional two's-complement negation, purely combinational.
module cond_negate #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Shift-add multiply, restoring divide, sign fix-up in a final step.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int ITERS = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(ITERS + 1);

    state_e              state_q, state_d;
    logic                is_div_q, neg_res_q, neg_rem_q, dz_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     rem_q, a_q, hi_q, lo_q;
    logic [CW-1:0]       cnt_q;
    logic                done_q, dbz_q;

    logic                is_signed, is_div, dz, last;
    logic                neg_rs, neg_rt;
    logic [XLEN-1:0]     rs_abs, rt_abs;
    logic [XLEN:0]       mul_sum, div_sh;
    logic                div_ok;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix;

    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign dz        = is_div && (rt_val == '0);
    assign last      = (cnt_q == CW'(ITERS - 1));
    assign neg_rs    = is_signed && rs_val[XLEN-1];
    assign neg_rt    = is_signed && rt_val[XLEN-1];

    cond_negate #(.W(XLEN)) u_abs_rs (
        .neg(neg_rs), .a(rs_val), .y(rs_abs)
    );
    cond_negate #(.W(XLEN)) u_abs_rt (
        .neg(neg_rt), .a(rt_val), .y(rt_abs)
    );
    cond_negate #(.W(2*XLEN)) u_fix_prod (
        .neg(neg_res_q), .a(acc_q), .y(prod_fix)
    );
    cond_negate #(.W(XLEN)) u_fix_quo (
        .neg(neg_res_q), .a(acc_q[XLEN-1:0]), .y(quo_fix)
    );
    cond_negate #(.W(XLEN)) u_fix_rem (
        .neg(neg_rem_q), .a(rem_q), .y(rem_fix)
    );

    // acc low half holds the multiplier / dividend shifting out,
    // product bits or quotient bits shift in behind it.
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                   + (acc_q[0] ? {1'b0, a_q} : '0);
    assign div_sh  = {rem_q, acc_q[XLEN-1]};
    assign div_ok  = (div_sh >= {1'b0, a_q});

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = dz ? DONE : CALC;
            CALC: if (last) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            acc_q     <= '0;
            rem_q     <= '0;
            a_q       <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        is_div_q  <= is_div;
                        neg_res_q <= neg_rs ^ neg_rt;
                        neg_rem_q <= is_div && neg_rs;
                        dz_q      <= dz;
                        cnt_q     <= '0;
                        if (dz) begin
                            acc_q <= {{XLEN{1'b0}}, {XLEN{1'b1}}};
                            rem_q <= rs_val;
                        end else if (is_div) begin
                            a_q   <= rt_abs;
                            acc_q <= {{XLEN{1'b0}}, rs_abs};
                            rem_q <= '0;
                        end else begin
                            a_q   <= rs_abs;
                            acc_q <= {{XLEN{1'b0}}, rt_abs};
                        end
                    end else begin
                        if (mthi) hi_q <= wdata;
                        if (mtlo) lo_q <= wdata;
                    end
                end
                CALC: begin
                    cnt_q <= last ? '0 : cnt_q + CW'(1);
                    if (is_div_q) begin
                        rem_q <= div_ok
                               ? XLEN'(div_sh - {1'b0, a_q})
                               : div_sh[XLEN-1:0];
                        acc_q[XLEN-1:0] <= {acc_q[XLEN-2:0], div_ok};
                    end else begin
                        acc_q <= {mul_sum, acc_q[XLEN-1:1]};
                    end
                end
                FIX: begin
                    if (is_div_q) begin
                        acc_q[XLEN-1:0] <= quo_fix;
                        rem_q           <= rem_fix;
                    end else begin
                        acc_q <= prod_fix;
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                    dbz_q  <= dz_q;
                    lo_q   <= acc_q[XLEN-1:0];
                    hi_q   <= is_div_q ? rem_q
                                       : acc_q[2*XLEN-1:XLEN];
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed table,
// multi-cycle corner sequences and random ops vs. an arithmetic model.
module tb_mul_div_unit;

    localparam int ITERS = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_err = 0;

    mul_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference results straight from MIPS arithmetic rules.
    task automatic model(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] h,
                         output logic [31:0] l, output logic z);
        longint      p;
        logic [63:0] pu;
        z = 1'b0;
        h = '0;
        l = '0;
        case (o)
            2'b00: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {h, l} = p;
            end
            2'b01: begin
                pu = {32'b0, a} * {32'b0, b};
                {h, l} = pu;
            end
            2'b10: begin
                if (b == 0) begin
                    z = 1'b1; l = '1; h = a;
                end else if (a == 32'h8000_0000 && b == '1) begin
                    l = a; h = '0;
                end else begin
                    l = $signed(a) / $signed(b);
                    h = $signed(a) % $signed(b);
                end
            end
            default: begin
                if (b == 0) begin
                    z = 1'b1; l = '1; h = a;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
    endtask

    // Drive start for one cycle; returns at the negedge after acceptance.
    task automatic start_op(input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic wr_hi);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        mthi = wr_hi; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        rs_val = $urandom; rt_val = $urandom;
    endtask

    // kind 1: extra start while busy; kind 2: mthi while busy.
    task automatic wait_done(input int inj_at, input int kind,
                             input logic [31:0] hi_before,
                             output int lat, output int bc);
        lat = 0;
        bc = busy ? 1 : 0;
        while (!done && lat < 200) begin
            if (lat == inj_at && kind == 1) begin
                start = 1'b1; op = 2'b10; rs_val = 1; rt_val = 0;
            end
            if (lat == inj_at && kind == 2) begin
                mthi = 1'b1; wdata = 32'h1234;
            end
            @(negedge clk);
            start = 1'b0; mthi = 1'b0;
            lat++;
            if (busy) bc++;
            if (kind == 2 && lat == inj_at + 1)
                chk("mthi_busy_hi", hi, hi_before);
        end
    endtask

    task automatic run_vec(input string nm, input vec_t v,
                           input int inj_at, input int kind,
                           input logic wr_hi);
        int          lat, bc;
        int          exp_lat;
        logic [31:0] hb;
        hb = hi;
        exp_lat = v.dz ? 1 : ITERS + 2;
        start_op(v.op, v.rs, v.rt, wr_hi);
        wait_done(inj_at, kind, hb, lat, bc);
        chk({nm, ".latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, ".busy_cycles"}, 64'(bc), 64'(exp_lat));
        chk({nm, ".hi"}, hi, v.hi);
        chk({nm, ".lo"}, lo, v.lo);
        chk({nm, ".dbz"}, div_by_zero, v.dz);
        @(negedge clk);
        chk({nm, ".done_clear"}, done, 1'b0);
        chk({nm, ".dbz_clear"}, div_by_zero, 1'b0);
    endtask

    initial begin
        vec_t tbl[8];
        vec_t v;
        tbl[0] = '{2'b00, 32'hFFFF_FFFD, 32'd7,
                   32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        tbl[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                   32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        tbl[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,
                   32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
                   32'h0000_0000, 32'h8000_0000, 1'b0};
        tbl[4] = '{2'b11, 32'd100, 32'd0,
                   32'd100, 32'hFFFF_FFFF, 1'b1};
        tbl[5] = '{2'b00, 32'h8000_0000, 32'h8000_0000,
                   32'h4000_0000, 32'h0000_0000, 1'b0};
        tbl[6] = '{2'b10, 32'd7, 32'hFFFF_FFFE,
                   32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        tbl[7] = '{2'b10, 32'd0, 32'd0,
                   32'h0000_0000, 32'hFFFF_FFFF, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.dbz", div_by_zero, 1'b0);
        chk("rst.hi", hi, 32'h0);
        chk("rst.lo", lo, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_vec($sformatf("vec%0d", i), tbl[i], -1, 0, 1'b0);

        // Second start while busy must be ignored.
        v = '{2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0};
        run_vec("start_busy", v, 9, 1, 1'b0);

        // mthi while busy is ignored.
        v = '{2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0};
        run_vec("mthi_busy", v, 5, 2, 1'b0);

        // mthi / mtlo in IDLE.
        @(negedge clk);
        mthi = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi_idle.hi", hi, 32'h1234);
        chk("mthi_idle.lo", lo, 32'd6);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        chk("mthilo.hi", hi, 32'hCAFE);
        chk("mthilo.lo", lo, 32'hCAFE);

        // Start wins over a same-cycle mthi.
        v = '{2'b01, 32'd1, 32'd1, 32'd0, 32'd1, 1'b0};
        run_vec("start_mthi", v, -1, 0, 1'b1);

        // Reset in the middle of a divide.
        begin
            int dpulse;
            dpulse = 0;
            start_op(2'b11, 32'd9, 32'd3, 1'b0);
            repeat (15) @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("midrst.busy", busy, 1'b0);
            chk("midrst.hi", hi, 32'h0);
            chk("midrst.lo", lo, 32'h0);
            repeat (3) begin
                @(negedge clk);
                if (done) dpulse++;
            end
            chk("midrst.no_done", 64'(dpulse), 64'd0);
            rst_n = 1'b1;
        end
        v = '{2'b11, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0};
        run_vec("after_rst", v, -1, 0, 1'b0);

        // Random operations against the arithmetic model.
        for (int i = 0; i < 150; i++) begin
            v.op = 2'($urandom_range(0, 3));
            v.rs = $urandom;
            v.rt = $urandom;
            if ($urandom_range(0, 7) == 0) v.rt = '0;
            if ($urandom_range(0, 9) == 0) v.rs = 32'h8000_0000;
            if ($urandom_range(0, 9) == 0) v.rt = 32'hFFFF_FFFF;
            if ($urandom_range(0, 3) == 0) v.rt = v.rt >> 24;
            model(v.op, v.rs, v.rt, v.hi, v.lo, v.dz);
            run_vec($sformatf("rnd%0d", i), v, -1, 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
